// File: rtl/jetson_tx_arbiter_if.sv
// Requester-side packet bus of the core-to-Jetson write arbiter.
// Master drives words; slave (the arbiter) returns per-requester ready.
interface jetson_tx_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req_valid;
   logic [32*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      req_last;
   logic [NREQ-1:0]      req_ready;

   modport master (
      output req_valid,
      output req_data,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      output req_ready
   );
endinterface

// File: rtl/jetson_tx_arbiter.sv
// Round-robin packet arbiter for the core-to-Jetson write port with status coalescing.
// Define JTX_BURST_LIMIT_EN to split grants after MAX_BURST words.
module jetson_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 16
) (
   input  logic               clk,
   input  logic               rst,
   jetson_tx_arbiter_if.slave req,
   input  logic               status_update,
   input  logic [12:0]        status_in,
   input  logic               fifo_urgent,
   output logic               wr_en,
   output logic [31:0]        wr_din,
   output logic [2:0]         grant_id,
   output logic               busy,
   output logic               proto_err
);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("NREQ out of range");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
      $error("MAX_BURST out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      STATUS,
      BURST
   } state_t;

   state_t      state, state_d;
   logic [2:0]  grant_d;
   logic [2:0]  rr_ptr, rr_d;
   logic        wr_en_d;
   logic [31:0] wr_din_d;
   logic        status_pending;
   logic [12:0] status_hold;

   logic [31:0]     sel_word;
   logic            sel_valid;
   logic            sel_last;
   logic [NREQ-1:0] elig;
   logic            found;
   logic [2:0]      win;
   logic            accept;
   logic            illegal;
   logic            perr_set;
   logic            burst_cut;

   assign busy = (state == BURST);

   always_comb begin
      req.req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (state == BURST && grant_id == 3'(i))
            req.req_ready[i] = 1'b1;
      end
   end

   always_comb begin
      sel_word  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == 3'(i)) begin
            sel_word  = req.req_data[32*i +: 32];
            sel_valid = req.req_valid[i];
            sel_last  = req.req_last[i];
         end
      end
   end

   // Urgent FIFO: only requester 0 may open a new packet.
   always_comb begin
      elig  = fifo_urgent ? (req.req_valid & {{(NREQ-1){1'b0}}, 1'b1})
                          : req.req_valid;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         automatic int idx = int'(rr_ptr) + k;
         if (idx >= NREQ)
            idx = idx - NREQ;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = 3'(idx);
         end
      end
   end

   assign accept   = (state == BURST) && sel_valid;
   assign illegal  = (sel_word[31:28] == 4'h0);
   assign perr_set = accept && illegal;

`ifdef JTX_BURST_LIMIT_EN
   logic [7:0] burst_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         burst_cnt <= '0;
      else if (state == IDLE)
         burst_cnt <= '0;
      else if (accept)
         burst_cnt <= burst_cnt + 8'd1;
   end

   assign burst_cut = (burst_cnt == 8'(MAX_BURST - 1));
`else
   assign burst_cut = 1'b0;
`endif

   always_comb begin
      state_d  = state;
      grant_d  = grant_id;
      rr_d     = rr_ptr;
      wr_en_d  = 1'b0;
      wr_din_d = wr_din;
      unique case (state)
         IDLE: begin
            if (status_pending) begin
               state_d = STATUS;
            end else if (found) begin
               state_d = BURST;
               grant_d = win;
               rr_d    = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
            end
         end
         STATUS: begin
            wr_en_d  = 1'b1;
            wr_din_d = {19'b0, status_hold};
            state_d  = IDLE;
         end
         BURST: begin
            if (accept) begin
               wr_en_d  = !illegal;
               wr_din_d = sel_word;
               if (sel_last || burst_cut)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         grant_id       <= '0;
         rr_ptr         <= '0;
         wr_en          <= 1'b0;
         wr_din         <= '0;
         proto_err      <= 1'b0;
         status_pending <= 1'b0;
         status_hold    <= '0;
      end else begin
         state    <= state_d;
         grant_id <= grant_d;
         rr_ptr   <= rr_d;
         wr_en    <= wr_en_d;
         wr_din   <= wr_din_d;
         if (perr_set)
            proto_err <= 1'b1;
         // A strobe landing on the emit cycle keeps the new value pending.
         if (status_update) begin
            status_pending <= 1'b1;
            status_hold    <= status_in;
         end else if (state == STATUS) begin
            status_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jetson_tx_arbiter.sv
// Scoreboard bench for jetson_tx_arbiter: per-requester word queues drive the
// bus, expected write words are queued up front and popped on every wr_en.
module tb_jetson_tx_arbiter;
   localparam int N = 4;

   logic        clk;
   logic        rst;
   logic        status_update;
   logic [12:0] status_in;
   logic        fifo_urgent;
   logic        wr_en;
   logic [31:0] wr_din;
   logic [2:0]  grant_id;
   logic        busy;
   logic        proto_err;

   jetson_tx_arbiter_if #(.NREQ(N)) bus ();

   jetson_tx_arbiter #(
      .NREQ      (N),
      .MAX_BURST (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (bus),
      .status_update (status_update),
      .status_in     (status_in),
      .fifo_urgent   (fifo_urgent),
      .wr_en         (wr_en),
      .wr_din        (wr_din),
      .grant_id      (grant_id),
      .busy          (busy),
      .proto_err     (proto_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [32:0] rq [N][$];
   logic [31:0] exp_q [$];

   int t_first_vld = -1;
   int t_first_rdy = -1;
   int t_first_wr  = -1;
   int t_last_wr   = -1;
   int g_seen      = -1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Requester model: offers the head of each queue, pops on handshake.
   initial begin
      logic [N-1:0]    pend;
      logic [N-1:0]    v;
      logic [N-1:0]    l;
      logic [32*N-1:0] d;
      pend = '0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = '0;
            bus.req_valid = '0;
            bus.req_last  = '0;
         end else begin
            for (int i = 0; i < N; i++)
               if (pend[i] && rq[i].size() > 0)
                  void'(rq[i].pop_front());
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
               if (rq[i].size() > 0) begin
                  v[i] = 1'b1;
                  l[i] = rq[i][0][32];
                  d[32*i +: 32] = rq[i][0][31:0];
               end
            end
            if (v[2] && t_first_vld < 0)
               t_first_vld = cyc;
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
            pend = bus.req_valid & bus.req_ready;
         end
      end
   end

   // Output monitor against the expected-word queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.req_ready[2] && t_first_rdy < 0) begin
               t_first_rdy = cyc;
               g_seen      = int'(grant_id);
            end
            if (wr_en) begin
               if (t_first_wr < 0)
                  t_first_wr = cyc;
               t_last_wr = cyc;
               if (exp_q.size() == 0)
                  chk("spurious_wr", {31'b0, wr_en}, 32'd0);
               else
                  chk("wr_din", wr_din, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++)
         rq[i].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_pkt(input int id, input logic [31:0] base,
                           input int n, input bit expect_out);
      for (int w = 0; w < n; w++) begin
         rq[id].push_back({(w == n - 1), base + 32'(w)});
         if (expect_out)
            exp_q.push_back(base + 32'(w));
      end
   endtask

   task automatic wait_drain(input string tag);
      int left;
      left = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         left = exp_q.size();
         for (int i = 0; i < N; i++)
            left += rq[i].size();
         if (left == 0 && !busy)
            break;
      end
      chk(tag, 32'(left), 32'd0);
   endtask

   task automatic strobe(input logic [12:0] v);
      status_update = 1'b1;
      status_in     = v;
      @(negedge clk);
      status_update = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      status_update = 1'b0;
      status_in     = '0;
      fifo_urgent   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("rst_wr_din", wr_din, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_perr", {31'b0, proto_err}, 32'd0);
      rst = 1'b0;

      // Single packet from requester 2
      @(negedge clk);
      t_first_vld = -1;
      t_first_rdy = -1;
      t_first_wr  = -1;
      t_last_wr   = -1;
      push_pkt(2, 32'h1000_0001, 3, 1'b1);
      wait_drain("single_drain");
      chk("grant_lat", 32'(t_first_rdy), 32'(t_first_vld + 1));
      chk("wr_lat", 32'(t_first_wr), 32'(t_first_rdy + 1));
      chk("wr_rate", 32'(t_last_wr - t_first_wr), 32'd2);
      chk("grant_id2", 32'(g_seen), 32'd2);
      chk("busy_after", {31'b0, busy}, 32'd0);
      // rr_ptr is now 3, so requester 3 beats requester 0
      push_pkt(3, 32'h1300_0001, 1, 1'b1);
      push_pkt(0, 32'h1000_0101, 1, 1'b1);
      wait_drain("rr_ptr3_drain");

      // Round robin with continuous 2-word packets
      do_reset();
      push_pkt(0, 32'h1000_0a00, 2, 1'b1);
      push_pkt(1, 32'h1001_0a00, 2, 1'b1);
      push_pkt(2, 32'h1002_0a00, 2, 1'b1);
      push_pkt(3, 32'h1003_0a00, 2, 1'b1);
      push_pkt(0, 32'h1000_0b00, 2, 1'b1);
      wait_drain("rr_drain");

      // Status coalescing during a 10-word burst
      do_reset();
      push_pkt(0, 32'h4000_0000, 10, 1'b1);
      exp_q.push_back(32'h0000_1abc);
      push_pkt(1, 32'h4100_0000, 2, 1'b1);
      repeat (3) @(negedge clk);
      strobe(13'h0011);
      strobe(13'h0022);
      strobe(13'h1abc);
      wait_drain("status_drain");

      // Urgent: requester 0 only, in-flight packet completes
      do_reset();
      push_pkt(0, 32'h1500_0001, 1, 1'b1);
      wait_drain("urg_pre_drain");
      fifo_urgent = 1'b1;
      push_pkt(1, 32'h1510_0001, 2, 1'b0);
      push_pkt(0, 32'h1500_0011, 2, 1'b1);
      exp_q.push_back(32'h1510_0001);
      exp_q.push_back(32'h1510_0002);
      for (int c = 0; c < 50 && rq[0].size() > 0; c++)
         @(negedge clk);
      repeat (6) @(negedge clk);
      chk("urg_r1_wait", 32'(rq[1].size()), 32'd2);
      chk("urg_idle", {31'b0, busy}, 32'd0);
      fifo_urgent = 1'b0;
      wait_drain("urg_release_drain");
      push_pkt(3, 32'h1530_0001, 4, 1'b1);
      for (int c = 0; c < 20 && !busy; c++)
         @(negedge clk);
      @(negedge clk);
      fifo_urgent = 1'b1;
      wait_drain("urg_inflight_drain");
      fifo_urgent = 1'b0;

      // Illegal word is consumed but not written
      do_reset();
      rq[1].push_back({1'b0, 32'h0000_1234});
      rq[1].push_back({1'b1, 32'h2000_0000});
      exp_q.push_back(32'h2000_0000);
      wait_drain("illegal_drain");
      chk("perr_set", {31'b0, proto_err}, 32'd1);
      push_pkt(2, 32'h2200_0001, 1, 1'b1);
      wait_drain("illegal_next_drain");
      chk("perr_sticky", {31'b0, proto_err}, 32'd1);
      do_reset();
      chk("perr_cleared", {31'b0, proto_err}, 32'd0);

      // Burst limit split versus contiguous grant
      push_pkt(0, 32'h3000_0000, 6, 1'b0);
      push_pkt(1, 32'h3100_0000, 2, 1'b0);
`ifdef JTX_BURST_LIMIT_EN
      for (int w = 0; w < 4; w++)
         exp_q.push_back(32'h3000_0000 + 32'(w));
      exp_q.push_back(32'h3100_0000);
      exp_q.push_back(32'h3100_0001);
      exp_q.push_back(32'h3000_0004);
      exp_q.push_back(32'h3000_0005);
`else
      for (int w = 0; w < 6; w++)
         exp_q.push_back(32'h3000_0000 + 32'(w));
      exp_q.push_back(32'h3100_0000);
      exp_q.push_back(32'h3100_0001);
`endif
      wait_drain("burst_drain");

      // Reset mid-packet drops everything asynchronously
      do_reset();
      push_pkt(2, 32'h6000_0000, 6, 1'b1);
      for (int c = 0; c < 20 && !busy; c++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      chk("mid_busy_pre", {31'b0, busy}, 32'd1);
      chk("mid_wr_pre", {31'b0, wr_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_busy", {31'b0, busy}, 32'd0);
      chk("mid_wr_en", {31'b0, wr_en}, 32'd0);
      chk("mid_ready", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < N; i++)
         rq[i].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_idle", {31'b0, wr_en}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
